alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (legal 1-15).
REQ-002 SHALL have parameter RING_MIN, default 10, ring auto-stop timeout in minutes (legal 1-15).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (legal 0-7).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 tick_1hz  in  1  one-clk-wide pulse, once per second.
REQ-008 min_tick  in  1  one-clk-wide pulse, once per minute.
REQ-009 clock_time  in  16  current time, BCD {HR1,HR0,MIN1,MIN0}.
REQ-010 alarm_time  in  16  alarm setting, same BCD format.
REQ-011 alarm_en  in  1  level; 1 = alarm armed.
REQ-012 load_active  in  1  level; 1 while clock or alarm digits are being loaded.
REQ-013 snooze_btn  in  1  debounced button level.
REQ-014 dismiss_btn  in  1  debounced button level.
REQ-015 state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-016 ringing  out  1  high exactly while state==RINGING.
REQ-017 buzzer  out  1  beep drive, 0.5 Hz square while RINGING, else 0.
REQ-018 snooze_cnt  out  3  snoozes taken in current alarm event.

Function
REQ-019 Buttons SHALL be rising-edge detected internally (btn=1 and previous-cycle btn=0); edge registers reset to 1 so a button held through reset gives no event.
REQ-020 match = (clock_time == alarm_time), full 16-bit compare; match_q SHALL register match every cycle regardless of state.
REQ-021 trigger = match & ~match_q & ~load_active; arming while already matching SHALL NOT fire.
REQ-022 Priority every cycle: alarm_en=0 > dismiss edge > snooze edge > timer events > trigger.
REQ-023 Any state with alarm_en=0 SHALL go to IDLE next cycle, clearing snooze_cnt, timers, buzzer.
REQ-024 IDLE -> ARMED when alarm_en=1.
REQ-025 ARMED -> RINGING on trigger; ring timer loads RING_MIN, buzzer=1 in the first RINGING cycle.
REQ-026 RINGING: buzzer SHALL toggle on each tick_1hz; ring timer SHALL decrement on each min_tick.
REQ-027 RINGING + dismiss edge -> ARMED, snooze_cnt cleared.
REQ-028 RINGING + snooze edge with snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt+1, snooze timer loads SNOOZE_MIN; with snooze_cnt == MAX_SNOOZE the edge SHALL be ignored.
REQ-029 RINGING + min_tick with ring timer == 1 -> ARMED, snooze_cnt cleared (auto-stop).
REQ-030 SNOOZE: snooze timer decrements on each min_tick; min_tick with timer == 1 -> RINGING with ring timer reloaded to RING_MIN and buzzer=1.
REQ-031 SNOOZE + dismiss edge -> ARMED, snooze_cnt cleared; snooze edge in SNOOZE ignored.
REQ-032 load_active SHALL only suppress trigger; it SHALL NOT alter RINGING or SNOOZE behaviour.
REQ-033 All outputs SHALL be registered; a qualifying input at edge N changes outputs after edge N.
REQ-034 Timers SHALL never wrap; decrement below 1 is impossible by REQ-029/030.

Reset
REQ-035 rst=1 SHALL force state=IDLE, ringing=0, buzzer=0, snooze_cnt=0, timers=0, match_q=1, button edge registers=1, regardless of other inputs.
REQ-036 Reset asserted mid-RINGING or mid-SNOOZE SHALL take effect at the next clk edge; after release, state goes to ARMED one cycle later if alarm_en=1.

Verification
REQ-037 alarm_en=1, alarm_time=16'h0700, clock_time 16'h0659 -> 16'h0700 -> ringing=1, state=2 one cycle later; buzzer toggles per tick_1hz.
REQ-038 Ringing, 3 snooze edges each followed by 5 min_ticks (defaults) -> snooze_cnt 1,2,3, returns to RINGING each time; 4th snooze edge ignored, state stays 2.
REQ-039 Ringing, 10 min_ticks with no buttons -> state=1, ringing=0, buzzer=0, snooze_cnt=0.
REQ-040 Same-cycle snooze and dismiss edges in RINGING -> state=1, snooze_cnt=0.
REQ-041 clock_time changed to equal alarm_time while load_active=1, then load_active=0 with time still equal -> no ring; alarm_en 0->1 while equal -> no ring.
REQ-042 rst pulsed in SNOOZE with snooze_btn held high -> state=0 then 1, snooze_cnt=0, no snooze event after release.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl -- alarm clock sequencing controller.
//
// Compares the running BCD clock against the alarm setting and, when armed,
// rings the buzzer. Snooze and dismiss buttons are edge-detected. A ring timer
// stops an unanswered alarm after RING_MIN minutes. A snooze timer brings the
// alarm back after SNOOZE_MIN minutes. Each alarm event allows MAX_SNOOZE
// snoozes.
//
// Ports
//   clk          system clock, rising-edge active
//   rst          synchronous active-high reset
//   tick_1hz     one-cycle pulse per second (buzzer cadence)
//   min_tick     one-cycle pulse per minute (ring/snooze timers)
//   clock_time   current time, BCD {HR1,HR0,MIN1,MIN0}
//   alarm_time   alarm setting, same format
//   alarm_en     level, alarm armed
//   load_active  level, time digits being loaded (suppresses trigger)
//   snooze_btn   debounced button level
//   dismiss_btn  debounced button level
//   state        IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
//   ringing      high while state==RINGING
//   buzzer       0.5 Hz square while RINGING, else 0
//   snooze_cnt   snoozes taken in the current alarm event
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | alarm disabled
// ARMED   | waiting for clock_time to reach alarm_time
// RINGING | buzzer active, ring timer counting minutes
// SNOOZE  | buzzer silent, snooze timer counting minutes

module alarm_ctrl #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        min_tick,
  input  logic [15:0] clock_time,
  input  logic [15:0] alarm_time,
  input  logic        alarm_en,
  input  logic        load_active,
  input  logic        snooze_btn,
  input  logic        dismiss_btn,
  output logic [1:0]  state,
  output logic        ringing,
  output logic        buzzer,
  output logic [2:0]  snooze_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] RINGING = 2'd2;
  localparam logic [1:0] SNOOZE  = 2'd3;

  localparam logic [3:0] RING_LD   = 4'(RING_MIN);
  localparam logic [3:0] SNOOZE_LD = 4'(SNOOZE_MIN);
  localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

  logic       snooze_q;
  logic       dismiss_q;
  logic       match_q;
  logic       match;
  logic       snooze_edge;
  logic       dismiss_edge;
  logic       trigger;
  logic [3:0] ring_tmr;
  logic [3:0] snz_tmr;

  logic [1:0] state_n;
  logic [3:0] ring_n;
  logic [3:0] snz_n;
  logic [2:0] cnt_n;
  logic       buzz_n;

  assign match        = (clock_time == alarm_time);
  assign snooze_edge  = snooze_btn & ~snooze_q;
  assign dismiss_edge = dismiss_btn & ~dismiss_q;
  // Only a fresh match fires, so arming or finishing a load while the times
  // already agree does not ring.
  assign trigger      = match & ~match_q & ~load_active;

  always_comb begin
    state_n = state;
    ring_n  = ring_tmr;
    snz_n   = snz_tmr;
    cnt_n   = snooze_cnt;
    buzz_n  = buzzer;

    if (!alarm_en) begin
      state_n = IDLE;
      ring_n  = 4'd0;
      snz_n   = 4'd0;
      cnt_n   = 3'd0;
      buzz_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARMED;
          buzz_n  = 1'b0;
        end

        ARMED: begin
          buzz_n = 1'b0;
          // A dismiss press outranks a trigger in the same cycle.
          if (trigger && !dismiss_edge) begin
            state_n = RINGING;
            ring_n  = RING_LD;
            buzz_n  = 1'b1;
          end
        end

        RINGING: begin
          if (dismiss_edge) begin
            state_n = ARMED;
            cnt_n   = 3'd0;
            ring_n  = 4'd0;
            buzz_n  = 1'b0;
          end else if (snooze_edge && (snooze_cnt < SNZ_MAX)) begin
            state_n = SNOOZE;
            cnt_n   = snooze_cnt + 3'd1;
            snz_n   = SNOOZE_LD;
            ring_n  = 4'd0;
            buzz_n  = 1'b0;
          end else begin
            // A snooze press past the limit falls through to normal ringing.
            if (tick_1hz)
              buzz_n = ~buzzer;
            if (min_tick) begin
              if (ring_tmr == 4'd1) begin
                state_n = ARMED;
                cnt_n   = 3'd0;
                ring_n  = 4'd0;
                buzz_n  = 1'b0;
              end else if (ring_tmr != 4'd0) begin
                ring_n = ring_tmr - 4'd1;
              end
            end
          end
        end

        SNOOZE: begin
          buzz_n = 1'b0;
          if (dismiss_edge) begin
            state_n = ARMED;
            cnt_n   = 3'd0;
            snz_n   = 4'd0;
          end else if (min_tick) begin
            if (snz_tmr == 4'd1) begin
              state_n = RINGING;
              ring_n  = RING_LD;
              snz_n   = 4'd0;
              buzz_n  = 1'b1;
            end else if (snz_tmr != 4'd0) begin
              snz_n = snz_tmr - 4'd1;
            end
          end
        end

        default: begin
          state_n = IDLE;
          ring_n  = 4'd0;
          snz_n   = 4'd0;
          cnt_n   = 3'd0;
          buzz_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
      snooze_cnt <= 3'd0;
      ring_tmr   <= 4'd0;
      snz_tmr    <= 4'd0;
      // Set high so a button held, or a time already matching, across reset
      // produces no event after release.
      match_q    <= 1'b1;
      snooze_q   <= 1'b1;
      dismiss_q  <= 1'b1;
    end else begin
      state      <= state_n;
      ringing    <= (state_n == RINGING);
      buzzer     <= buzz_n;
      snooze_cnt <= cnt_n;
      ring_tmr   <= ring_n;
      snz_tmr    <= snz_n;
      match_q    <= match;
      snooze_q   <= snooze_btn;
      dismiss_q  <= dismiss_btn;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

  logic        clk;
  logic        rst;
  logic        tick_1hz;
  logic        min_tick;
  logic [15:0] clock_time;
  logic [15:0] alarm_time;
  logic        alarm_en;
  logic        load_active;
  logic        snooze_btn;
  logic        dismiss_btn;
  logic [1:0]  state;
  logic        ringing;
  logic        buzzer;
  logic [2:0]  snooze_cnt;

  int vecs = 0;
  int errs = 0;

  alarm_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .min_tick    (min_tick),
    .clock_time  (clock_time),
    .alarm_time  (alarm_time),
    .alarm_en    (alarm_en),
    .load_active (load_active),
    .snooze_btn  (snooze_btn),
    .dismiss_btn (dismiss_btn),
    .state       (state),
    .ringing     (ringing),
    .buzzer      (buzzer),
    .snooze_cnt  (snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_min();
    min_tick = 1'b1; cyc(); min_tick = 1'b0; cyc();
  endtask

  task automatic pulse_sec();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
  endtask

  task automatic ring_up();
    clock_time = 16'h0659; cyc();
    clock_time = 16'h0700; cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; alarm_en = 1'b1; cyc(); cyc();
    vecs++; if (state !== 2'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", state); end
    vecs++; if (ringing !== 1'b0 || buzzer !== 1'b0) begin errs++; $display("FAIL reset_outs ringing %b buzzer %b exp 0 0", ringing, buzzer); end
    vecs++; if (snooze_cnt !== 3'd0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", snooze_cnt); end
    rst = 1'b0; cyc();
    vecs++; if (state !== 2'd1) begin errs++; $display("FAIL reset_arm got %0d exp 1", state); end
  endtask

  task automatic test_trigger();
    clock_time = 16'h0700; cyc();
    vecs++; if (state !== 2'd2 || ringing !== 1'b1) begin errs++; $display("FAIL trig_ring state %0d ringing %b exp 2 1", state, ringing); end
    vecs++; if (buzzer !== 1'b1) begin errs++; $display("FAIL trig_buzz got %b exp 1", buzzer); end
    pulse_sec();
    vecs++; if (buzzer !== 1'b0) begin errs++; $display("FAIL buzz_tog1 got %b exp 0", buzzer); end
    cyc();
    vecs++; if (buzzer !== 1'b0) begin errs++; $display("FAIL buzz_hold got %b exp 0", buzzer); end
    pulse_sec();
    vecs++; if (buzzer !== 1'b1) begin errs++; $display("FAIL buzz_tog2 got %b exp 1", buzzer); end
  endtask

  task automatic test_snooze();
    for (int i = 1; i <= 3; i++) begin
      snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0;
      vecs++; if (state !== 2'd3 || snooze_cnt !== 3'(i)) begin errs++; $display("FAIL snz_enter%0d state %0d cnt %0d exp 3 %0d", i, state, snooze_cnt, i); end
      vecs++; if (buzzer !== 1'b0 || ringing !== 1'b0) begin errs++; $display("FAIL snz_quiet%0d buzzer %b ringing %b exp 0 0", i, buzzer, ringing); end
      for (int m = 0; m < 4; m++) pulse_min();
      vecs++; if (state !== 2'd3) begin errs++; $display("FAIL snz_wait%0d got %0d exp 3", i, state); end
      pulse_min();
      vecs++; if (state !== 2'd2 || buzzer !== 1'b1 || snooze_cnt !== 3'(i)) begin errs++; $display("FAIL snz_back%0d state %0d buzzer %b cnt %0d exp 2 1 %0d", i, state, buzzer, snooze_cnt, i); end
    end
    snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0; cyc();
    vecs++; if (state !== 2'd2 || snooze_cnt !== 3'd3) begin errs++; $display("FAIL snz_limit state %0d cnt %0d exp 2 3", state, snooze_cnt); end
    dismiss_btn = 1'b1; cyc(); dismiss_btn = 1'b0;
    vecs++; if (state !== 2'd1 || snooze_cnt !== 3'd0 || buzzer !== 1'b0 || ringing !== 1'b0) begin errs++; $display("FAIL dismiss state %0d cnt %0d buzzer %b ringing %b exp 1 0 0 0", state, snooze_cnt, buzzer, ringing); end
  endtask

  task automatic test_autostop();
    ring_up();
    snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0;
    for (int m = 0; m < 5; m++) pulse_min();
    vecs++; if (state !== 2'd2 || snooze_cnt !== 3'd1) begin errs++; $display("FAIL auto_pre state %0d cnt %0d exp 2 1", state, snooze_cnt); end
    for (int m = 0; m < 9; m++) pulse_min();
    vecs++; if (state !== 2'd2) begin errs++; $display("FAIL auto_nine got %0d exp 2", state); end
    pulse_min();
    vecs++; if (state !== 2'd1 || ringing !== 1'b0 || buzzer !== 1'b0 || snooze_cnt !== 3'd0) begin errs++; $display("FAIL auto_stop state %0d ringing %b buzzer %b cnt %0d exp 1 0 0 0", state, ringing, buzzer, snooze_cnt); end
  endtask

  task automatic test_both_btns();
    ring_up();
    snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0;
    for (int m = 0; m < 5; m++) pulse_min();
    snooze_btn = 1'b1; dismiss_btn = 1'b1; cyc();
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
    vecs++; if (state !== 2'd1 || snooze_cnt !== 3'd0) begin errs++; $display("FAIL both_btns state %0d cnt %0d exp 1 0", state, snooze_cnt); end
  endtask

  task automatic test_load_and_disable();
    clock_time = 16'h0800; cyc();
    load_active = 1'b1; clock_time = 16'h0700; cyc();
    vecs++; if (state !== 2'd1) begin errs++; $display("FAIL load_hold got %0d exp 1", state); end
    load_active = 1'b0; cyc(); cyc();
    vecs++; if (state !== 2'd1 || ringing !== 1'b0) begin errs++; $display("FAIL load_release state %0d ringing %b exp 1 0", state, ringing); end
    alarm_en = 1'b0; cyc();
    vecs++; if (state !== 2'd0) begin errs++; $display("FAIL disarm got %0d exp 0", state); end
    alarm_en = 1'b1; cyc(); cyc(); cyc();
    vecs++; if (state !== 2'd1 || ringing !== 1'b0) begin errs++; $display("FAIL arm_equal state %0d ringing %b exp 1 0", state, ringing); end
    ring_up();
    alarm_en = 1'b0; cyc();
    vecs++; if (state !== 2'd0 || ringing !== 1'b0 || buzzer !== 1'b0) begin errs++; $display("FAIL disable_ring state %0d ringing %b buzzer %b exp 0 0 0", state, ringing, buzzer); end
    alarm_en = 1'b1; cyc();
  endtask

  task automatic test_reset_in_snooze();
    ring_up();
    snooze_btn = 1'b1; cyc();
    vecs++; if (state !== 2'd3 || snooze_cnt !== 3'd1) begin errs++; $display("FAIL rs_snz state %0d cnt %0d exp 3 1", state, snooze_cnt); end
    rst = 1'b1; cyc();
    vecs++; if (state !== 2'd0 || snooze_cnt !== 3'd0) begin errs++; $display("FAIL rs_reset state %0d cnt %0d exp 0 0", state, snooze_cnt); end
    rst = 1'b0; cyc();
    vecs++; if (state !== 2'd1) begin errs++; $display("FAIL rs_arm got %0d exp 1", state); end
    ring_up();
    vecs++; if (state !== 2'd2) begin errs++; $display("FAIL rs_ring got %0d exp 2", state); end
    cyc();
    vecs++; if (state !== 2'd2 || snooze_cnt !== 3'd0) begin errs++; $display("FAIL rs_held state %0d cnt %0d exp 2 0", state, snooze_cnt); end
    snooze_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; min_tick = 1'b0;
    clock_time = 16'h0659; alarm_time = 16'h0700;
    alarm_en = 1'b1; load_active = 1'b0;
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
    test_reset();
    test_trigger();
    test_snooze();
    test_autostop();
    test_both_btns();
    test_load_and_disable();
    test_reset_in_snooze();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
